control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/custom_types.sv | 62 ++++++
 rtl/control_decoder.sv | 83 ++++++++
 rtl/control_unit.sv | 90 +++++++++
 tb/tb_control_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/custom_types.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | custom_types : opcode, controller state, ALU op and mux-select constants  |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
package custom_types;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_LDI  = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_operation_t;

    localparam logic [1:0] C_SEL1_REG_RD   = 2'd0;
    localparam logic [1:0] C_SEL1_IMM4     = 2'd1;
    localparam logic [1:0] C_SEL1_ONE      = 2'd2;
    localparam logic [1:0] C_SEL1_ZERO     = 2'd3;

    localparam logic [1:0] C_SEL2_IMM2     = 2'd0;
    localparam logic [1:0] C_SEL2_PC       = 2'd1;
    localparam logic [1:0] C_SEL2_REG_RS   = 2'd2;
    localparam logic [1:0] C_SEL2_ZERO     = 2'd3;

    localparam logic [1:0] C_RES_MEM       = 2'd0;
    localparam logic [1:0] C_RES_ALU_REG   = 2'd1;
    localparam logic [1:0] C_RES_ALU_LIVE  = 2'd2;

    function automatic logic is_alu_op(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Opcodes that spend a cycle in EXECUTE; NOP and undefined values do not.
    function automatic logic needs_execute(input opcode_t op);
        return is_alu_op(op) || (op == OP_LDI) || (op == OP_LD) || (op == OP_ST) ||
               (op == OP_JMP) || (op == OP_JZ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_decoder : combinational control outputs from state/opcode/zero    |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module control_decoder
    import custom_types::*;
(
    input  ctrl_state_t    state,
    input  opcode_t        opcode,
    input  logic           zero,
    output logic           ir_write,
    output logic           pc_write,
    output logic           reg_write,
    output logic           mem_write,
    output logic           alu_write,
    output logic           zero_write,
    output logic [1:0]     alu_sel1,
    output logic [1:0]     alu_sel2,
    output alu_operation_t alu_op,
    output logic [1:0]     result_sel,
    output logic           halted
);

    always_comb begin
        // Selects idle at the PC-increment setting so quiet cycles stay deterministic.
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_write  = 1'b0;
        zero_write = 1'b0;
        alu_sel1   = C_SEL1_ONE;
        alu_sel2   = C_SEL2_PC;
        alu_op     = ALU_ADD;
        result_sel = C_RES_ALU_LIVE;
        halted     = 1'b0;

        case (state)
            ST_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            ST_DECODE: ;
            ST_EXECUTE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        alu_sel1   = C_SEL1_REG_RD;
                        alu_sel2   = C_SEL2_REG_RS;
                        alu_write  = 1'b1;
                        zero_write = 1'b1;
                        case (opcode)
                            OP_SUB:  alu_op = ALU_SUB;
                            OP_AND:  alu_op = ALU_AND;
                            OP_OR:   alu_op = ALU_OR;
                            default: alu_op = ALU_ADD;
                        endcase
                    end
                    OP_LDI: begin
                        alu_sel1  = C_SEL1_ZERO;
                        alu_sel2  = C_SEL2_IMM2;
                        reg_write = 1'b1;
                    end
                    OP_ST: mem_write = 1'b1;
                    OP_JMP, OP_JZ: begin
                        alu_sel1 = C_SEL1_IMM4;
                        alu_sel2 = C_SEL2_ZERO;
                        pc_write = (opcode == OP_JMP) || zero;
                    end
                    default: ;
                endcase
            end
            ST_WRITEBACK: begin
                reg_write  = 1'b1;
                result_sel = (opcode == OP_LD) ? C_RES_MEM : C_RES_ALU_REG;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_unit : multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK/HALT controller |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module control_unit
    import custom_types::*;
(
    input  logic           clk,
    input  logic           reset,
    input  opcode_t        opcode,
    input  logic           zero,
    output logic           ir_write,
    output logic           pc_write,
    output logic           reg_write,
    output logic           mem_write,
    output logic           alu_write,
    output logic           zero_write,
    output logic [1:0]     alu_sel1,
    output logic [1:0]     alu_sel2,
    output alu_operation_t alu_op,
    output logic [1:0]     result_sel,
    output logic           halted
);

    ctrl_state_t r_state;

    logic w_ir_write;
    logic w_pc_write;
    logic w_reg_write;
    logic w_mem_write;
    logic w_alu_write;
    logic w_zero_write;
    logic w_halted;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH:  r_state <= ST_DECODE;
                ST_DECODE: begin
                    if (opcode == OP_HALT)
                        r_state <= ST_HALT;
                    else if (needs_execute(opcode))
                        r_state <= ST_EXECUTE;
                    else
                        r_state <= ST_FETCH;
                end
                ST_EXECUTE: begin
                    if (is_alu_op(opcode) || (opcode == OP_LD))
                        r_state <= ST_WRITEBACK;
                    else
                        r_state <= ST_FETCH;
                end
                ST_WRITEBACK: r_state <= ST_FETCH;
                ST_HALT:      r_state <= ST_HALT;
                default:      r_state <= ST_FETCH;
            endcase
        end
    end

    control_decoder u_decoder (
        .state      (r_state),
        .opcode     (opcode),
        .zero       (zero),
        .ir_write   (w_ir_write),
        .pc_write   (w_pc_write),
        .reg_write  (w_reg_write),
        .mem_write  (w_mem_write),
        .alu_write  (w_alu_write),
        .zero_write (w_zero_write),
        .alu_sel1   (alu_sel1),
        .alu_sel2   (alu_sel2),
        .alu_op     (alu_op),
        .result_sel (result_sel),
        .halted     (w_halted)
    );

    // The state sits in FETCH during reset, so enables are masked directly by reset.
    assign ir_write   = reset & w_ir_write;
    assign pc_write   = reset & w_pc_write;
    assign reg_write  = reset & w_reg_write;
    assign mem_write  = reset & w_mem_write;
    assign alu_write  = reset & w_alu_write;
    assign zero_write = reset & w_zero_write;
    assign halted     = reset & w_halted;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_control_unit : random/directed bench against an instruction-level model|
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_control_unit;
    import custom_types::*;

    typedef struct packed {
        logic [5:0]     en;   // {ir, pc, reg, mem, alu, zero}
        logic [1:0]     s1;
        logic [1:0]     s2;
        alu_operation_t op;
        logic [1:0]     res;
        logic           hlt;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    opcode_t        opcode;
    logic           zero;
    logic           ir_write, pc_write, reg_write, mem_write, alu_write, zero_write;
    logic [1:0]     alu_sel1, alu_sel2, result_sel;
    alu_operation_t alu_op;
    logic           halted;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .alu_write  (alu_write),
        .zero_write (zero_write),
        .alu_sel1   (alu_sel1),
        .alu_sel2   (alu_sel2),
        .alu_op     (alu_op),
        .result_sel (result_sel),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Cycles per instruction; HALT counts fetch+decode, then stays halted.
    function automatic int lat(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h6: return 4;
            4'h5, 4'h7, 4'h8, 4'h9:       return 3;
            default:                      return 2;
        endcase
    endfunction

    // Expected controls for cycle k of an instruction with opcode op.
    function automatic exp_t expect_of(input logic [3:0] op, input int k, input logic z, input logic hlt);
        exp_t e;
        e.en  = 6'b000000;
        e.s1  = 2'd2;
        e.s2  = 2'd1;
        e.op  = ALU_ADD;
        e.res = 2'd2;
        e.hlt = hlt;
        if (!hlt) begin
            if (k == 0) begin
                e.en = 6'b110000;
            end else if (k == 2) begin
                case (op)
                    4'h1: begin e.s1 = 2'd0; e.s2 = 2'd2; e.op = ALU_ADD; e.en = 6'b000011; end
                    4'h2: begin e.s1 = 2'd0; e.s2 = 2'd2; e.op = ALU_SUB; e.en = 6'b000011; end
                    4'h3: begin e.s1 = 2'd0; e.s2 = 2'd2; e.op = ALU_AND; e.en = 6'b000011; end
                    4'h4: begin e.s1 = 2'd0; e.s2 = 2'd2; e.op = ALU_OR;  e.en = 6'b000011; end
                    4'h5: begin e.s1 = 2'd3; e.s2 = 2'd0; e.en = 6'b001000; end
                    4'h7: e.en = 6'b000100;
                    4'h8: begin e.s1 = 2'd1; e.s2 = 2'd3; e.en = 6'b010000; end
                    4'h9: begin e.s1 = 2'd1; e.s2 = 2'd3; e.en = {1'b0, z, 4'b0000}; end
                    default: ;
                endcase
            end else if (k == 3) begin
                e.en  = 6'b001000;
                e.res = (op == 4'h6) ? 2'd0 : 2'd1;
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic [3:0] op, input int k, input logic z, input logic hlt);
        exp_t e;
        e = expect_of(op, k, z, hlt);
        chk({tag, ".en"},  32'({ir_write, pc_write, reg_write, mem_write, alu_write, zero_write}), 32'(e.en));
        chk({tag, ".s1"},  32'(alu_sel1), 32'(e.s1));
        chk({tag, ".s2"},  32'(alu_sel2), 32'(e.s2));
        chk({tag, ".op"},  32'(alu_op), 32'(e.op));
        chk({tag, ".res"}, 32'(result_sel), 32'(e.res));
        chk({tag, ".hlt"}, 32'(halted), 32'(e.hlt));
    endtask

    // Called at posedge+1 with the DUT about to spend a cycle in FETCH.
    task automatic run_partial(input string tag, input logic [3:0] op, input int n, input int zsel);
        for (int k = 0; k < n; k++) begin
            opcode = opcode_t'(op);
            zero   = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
            @(negedge clk);
            check_cycle($sformatf("%s.op%0h.k%0d", tag, op, k), op, k, zero, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op, input int zsel);
        run_partial(tag, op, lat(op), zsel);
    endtask

    initial begin
        logic [3:0] rop;
        reset  = 1'b0;
        opcode = OP_ADD;
        zero   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_cycle("reset", 4'h1, 1, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        run_instr("add",  4'h1, 2);
        run_instr("jz0",  4'h9, 0);
        run_instr("jz1",  4'h9, 1);
        run_instr("ld",   4'h6, 2);
        run_instr("st",   4'h7, 2);
        run_instr("undef", 4'hC, 2);

        for (int n = 0; n < 60; n++) begin
            rop = 4'($urandom_range(0, 14));
            run_instr("rand", rop, 2);
        end

        // Abort a store in the middle of its EXECUTE cycle.
        run_partial("stabort", 4'h7, 2, 0);
        #1 check_cycle("st_exec", 4'h7, 2, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1 check_cycle("rst_abort", 4'h7, 1, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_cycle("rst_hold", 4'h7, 1, 1'b0, 1'b0);
        reset = 1'b1;
        run_instr("after_abort", 4'h2, 2);

        run_instr("halt", 4'hF, 2);
        for (int i = 0; i < 12; i++) begin
            opcode = opcode_t'(4'($urandom_range(0, 15)));
            zero   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_cycle($sformatf("halted.c%0d", i), 4'hF, 0, zero, 1'b1);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1 check_cycle("halt_rst", 4'hF, 1, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        run_instr("post_halt", 4'h1, 2);
        run_instr("post_halt", 4'h5, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
